// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and helper functions for the sync FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int c_MODE_STD  = 0;
  localparam int c_MODE_FWFT = 1;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Modulo increment for pointers into a memory of arbitrary (non power-of-2) depth
  function automatic logic [31:0] ptr_inc_mod(input logic [31:0] ptr, input logic [31:0] depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_regfile.sv
`default_nettype none
// ============================================================================
// Module      : fifo_regfile
// Description : WIDTH x DEPTH storage, one synchronous write, one async read.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_regfile #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/fifo_sync_prog.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_prog
// Description : Single-clock FIFO with count, threshold flags, sticky errors,
//               flush and selectable standard / first-word-fall-through read.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_prog
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2,
  parameter int FWFT      = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          push,
  input  logic [WIDTH-1:0]              datain,
  input  logic                          pop,
  output logic [WIDTH-1:0]              dataout,
  output logic [count_width(DEPTH)-1:0] fifo_count,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic                          fifo_almost_empty,
  output logic                          fifo_almost_full,
  input  logic                          err_clr,
  output logic                          fifo_overflow,
  output logic                          fifo_underflow
);

  localparam int c_CNT_W = count_width(DEPTH);
  localparam int c_PTR_W = $clog2(DEPTH);

  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_overflow;
  logic               r_underflow;
  logic               w_push_ok;
  logic               w_pop_ok;
  logic               w_we;
  logic [WIDTH-1:0]   w_rd_data;

  assign fifo_empty        = (r_count == '0);
  assign fifo_full         = (r_count == c_CNT_W'(DEPTH));
  assign fifo_almost_empty = (r_count <= c_CNT_W'(AE_MARGIN));
  assign fifo_almost_full  = (r_count >= c_CNT_W'(DEPTH - AF_MARGIN));
  assign fifo_count        = r_count;
  assign fifo_overflow     = r_overflow;
  assign fifo_underflow    = r_underflow;

  // A push into a full FIFO is only legal when a pop frees a slot the same cycle
  assign w_pop_ok  = pop & ~fifo_empty;
  assign w_push_ok = push & (~fifo_full | w_pop_ok);
  assign w_we      = w_push_ok & ~flush & ~rst;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= c_PTR_W'(ptr_inc_mod(32'(r_wr_ptr), 32'(DEPTH)));
      end
      if (w_pop_ok) begin
        r_rd_ptr <= c_PTR_W'(ptr_inc_mod(32'(r_rd_ptr), 32'(DEPTH)));
      end
      r_count <= r_count + c_CNT_W'(w_push_ok) - c_CNT_W'(w_pop_ok);
    end
  end

  // Error flags survive flush; a fresh error outranks err_clr
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (!flush) begin
      r_overflow  <= (push & ~w_push_ok) | (r_overflow & ~err_clr);
      r_underflow <= (pop & ~w_pop_ok) | (r_underflow & ~err_clr);
    end
  end

  fifo_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (datain),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  generate
    if (FWFT == c_MODE_FWFT) begin : g_fwft
      assign dataout = fifo_empty ? '0 : w_rd_data;
    end else begin : g_std
      logic [WIDTH-1:0] r_dataout;
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          r_dataout <= '0;
        end else if (w_pop_ok) begin
          r_dataout <= w_rd_data;
        end
      end
      assign dataout = r_dataout;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_sync_prog
// Description : Self-checking bench: standard/16, standard/12 and FWFT/16
//               instances driven in lockstep against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_prog;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic        err_clr = 1'b0;
  logic [15:0] datain = '0;

  logic [15:0] dout0, dout1, dout2;
  logic [4:0]  cnt0, cnt2;
  logic [3:0]  cnt1;
  logic        emp0, emp1, emp2, ful0, ful1, ful2;
  logic        ae0, ae1, ae2, af0, af1, af2;
  logic        ovf0, ovf1, ovf2, unf0, unf1, unf2;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  fifo_sync_prog #(.WIDTH(16), .DEPTH(16), .AF_MARGIN(2), .AE_MARGIN(2), .FWFT(0)) u_std16 (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .datain(datain), .pop(pop),
    .dataout(dout0), .fifo_count(cnt0), .fifo_empty(emp0), .fifo_full(ful0),
    .fifo_almost_empty(ae0), .fifo_almost_full(af0), .err_clr(err_clr),
    .fifo_overflow(ovf0), .fifo_underflow(unf0));

  fifo_sync_prog #(.WIDTH(16), .DEPTH(12), .AF_MARGIN(2), .AE_MARGIN(2), .FWFT(0)) u_std12 (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .datain(datain), .pop(pop),
    .dataout(dout1), .fifo_count(cnt1), .fifo_empty(emp1), .fifo_full(ful1),
    .fifo_almost_empty(ae1), .fifo_almost_full(af1), .err_clr(err_clr),
    .fifo_overflow(ovf1), .fifo_underflow(unf1));

  fifo_sync_prog #(.WIDTH(16), .DEPTH(16), .AF_MARGIN(2), .AE_MARGIN(2), .FWFT(1)) u_fwft16 (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .datain(datain), .pop(pop),
    .dataout(dout2), .fifo_count(cnt2), .fifo_empty(emp2), .fifo_full(ful2),
    .fifo_almost_empty(ae2), .fifo_almost_full(af2), .err_clr(err_clr),
    .fifo_overflow(ovf2), .fifo_underflow(unf2));

  // Reference model: one queue per instance plus sticky flags and the registered read word
  logic [15:0] mq [3][$];
  int          dep [3]    = '{16, 12, 16};
  bit          m_ovf [3]  = '{0, 0, 0};
  bit          m_unf [3]  = '{0, 0, 0};
  logic [15:0] m_dout [3] = '{16'h0, 16'h0, 16'h0};

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_dut(input int k);
    int          sz;
    logic [31:0] o_cnt, o_dout;
    logic        o_emp, o_ful, o_ae, o_af, o_ovf, o_unf;
    logic [15:0] exp_dout;
    sz = mq[k].size();
    case (k)
      0: begin o_cnt = 32'(cnt0); o_dout = 32'(dout0); o_emp = emp0; o_ful = ful0;
               o_ae = ae0; o_af = af0; o_ovf = ovf0; o_unf = unf0; end
      1: begin o_cnt = 32'(cnt1); o_dout = 32'(dout1); o_emp = emp1; o_ful = ful1;
               o_ae = ae1; o_af = af1; o_ovf = ovf1; o_unf = unf1; end
      default: begin o_cnt = 32'(cnt2); o_dout = 32'(dout2); o_emp = emp2; o_ful = ful2;
               o_ae = ae2; o_af = af2; o_ovf = ovf2; o_unf = unf2; end
    endcase
    if (k == 2) exp_dout = (sz != 0) ? mq[k][0] : 16'h0;
    else        exp_dout = m_dout[k];
    chk("count", k, o_cnt, 32'(sz));
    chk("empty", k, 32'(o_emp), 32'(sz == 0));
    chk("full", k, 32'(o_ful), 32'(sz == dep[k]));
    chk("almost_empty", k, 32'(o_ae), 32'(sz <= 2));
    chk("almost_full", k, 32'(o_af), 32'(sz >= dep[k] - 2));
    chk("overflow", k, 32'(o_ovf), 32'(m_ovf[k]));
    chk("underflow", k, 32'(o_unf), 32'(m_unf[k]));
    chk("dataout", k, o_dout, 32'(exp_dout));
  endtask

  task automatic step(input bit r, input bit f, input bit pu, input bit po, input bit ec,
                      input logic [15:0] d);
    rst = r; flush = f; push = pu; pop = po; err_clr = ec; datain = d;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      int sz;
      bit pop_acc, push_acc;
      sz = mq[k].size();
      pop_acc  = 1'b0;
      push_acc = 1'b0;
      if (r) begin
        mq[k].delete();
        m_ovf[k] = 1'b0; m_unf[k] = 1'b0; m_dout[k] = 16'h0;
      end else if (f) begin
        mq[k].delete();
        m_dout[k] = 16'h0;
      end else begin
        pop_acc  = po && (sz != 0);
        push_acc = pu && ((sz < dep[k]) || pop_acc);
        m_ovf[k] = (pu && !push_acc) || (m_ovf[k] && !ec);
        m_unf[k] = (po && !pop_acc) || (m_unf[k] && !ec);
        if (pop_acc)  m_dout[k] = mq[k].pop_front();
        if (push_acc) mq[k].push_back(d);
      end
    end
    #1;
    for (int k = 0; k < 3; k++) check_dut(k);
  endtask

  initial begin
    bit started;
    int pct;

    step(1, 0, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 0, 16'h0);

    // Fill past full, then drain past empty, then clear errors
    for (int i = 0; i < 17; i++) step(0, 0, 1, 0, 0, 16'(i));
    for (int i = 0; i < 17; i++) step(0, 0, 0, 1, 0, 16'h0);
    step(0, 0, 0, 0, 1, 16'h0);

    // Push+pop at full, then at empty
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0, 16'(100 + i));
    step(0, 0, 1, 1, 0, 16'h00EE);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0, 16'h0);
    step(0, 0, 1, 1, 0, 16'h0077);

    // Flush with a push pending; errors must survive
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 16'(200 + i));
    step(0, 1, 1, 0, 0, 16'hDEAD);
    step(0, 0, 0, 0, 1, 16'h0);

    // Streaming, pop enabled once the 16-deep instance reaches 8
    started = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (mq[0].size() >= 8) started = 1'b1;
      step(0, 0, 1, started, 0, 16'(i));
    end
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0, 16'h0);
    step(0, 0, 0, 0, 1, 16'h0);

    // FWFT head visibility
    step(0, 0, 1, 0, 0, 16'hA5A5);
    step(0, 0, 0, 0, 0, 16'h0);
    step(0, 0, 0, 1, 0, 16'h0);

    // Reset mid-stream
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 16'(300 + i));
    step(1, 0, 1, 1, 0, 16'h1234);
    step(0, 0, 0, 0, 0, 16'h0);

    // Randomised traffic with shifting push bias
    for (int i = 0; i < 3000; i++) begin
      bit r, f, ec, pu, po;
      pct = (i < 1000) ? 70 : ((i < 2000) ? 30 : 50);
      r  = ($urandom % 400) == 0;
      f  = ($urandom % 60) == 0;
      ec = !f && (($urandom % 25) == 0);
      pu = ($urandom % 100) < pct;
      po = ($urandom % 100) < 50;
      step(r, f, pu, po, ec, 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
